// File: rtl/rb_access_arbiter_pkg.sv
// Shared types and widths for the register-bank access arbiter.
//   rb_arb_owner_t : arbiter FSM state, also reported on the owner port
//                    (0 = IDLE, 1 = I2C, 2 = UART).
//   RB_ADDR_W      : register-bank address width.
//   RB_DATA_W      : register-bank data width.
package rb_access_arbiter_pkg;

  localparam int RB_ADDR_W = 8;
  localparam int RB_DATA_W = 8;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_I2C  = 2'd1,
    ARB_UART = 2'd2
  } rb_arb_owner_t;

endpackage

// File: rtl/rb_arb_drop_cnt.sv
// Dropped-access counter for one host.
// A new access is the rising edge of the host's raw reg_en. When that edge
// arrives while the host is not selected, the access is dropped and counted
// once. The count saturates at all-ones. clr wins over a same-cycle increment.
// Ports:
//   clk, resetb : clock, asynchronous active-low reset
//   reg_en      : raw host access strobe
//   selected    : host is selected by the arbiter this cycle
//   clr         : synchronous clear of the count
//   cnt         : saturating dropped-access count
module rb_arb_drop_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             reg_en,
  input  logic             selected,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic reg_en_q;
  logic drop;

  // The edge register follows reg_en in every arbiter state, so a strobe
  // held across a grant or release is never seen as a second access.
  assign drop = reg_en & ~reg_en_q & ~selected;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      reg_en_q <= 1'b0;
      cnt      <= '0;
    end else begin
      reg_en_q <= reg_en;
      if (clr) begin
        cnt <= '0;
      end else if (drop && (cnt != {CNT_W{1'b1}})) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/rb_access_arbiter.sv
// Shares one register-bank port between the I2C and UART host interfaces.
// The first host to strobe from IDLE owns the port for a session; the other
// host's accesses are dropped (and counted) until the owner has been quiet
// for IDLE_TIMEOUT cycles.
//
// Host interface semantics: a host presents address/wdata/write_en together
// with reg_en high for as long as it is accessing. There is no ready/stall;
// a selected host's access is forwarded to rb_* one clock later, a
// non-selected host's access is silently discarded. Read data is combinational
// from rb_address, so a host samples rdata two or more clocks after
// presenting its address.
//
// Ports:
//   clk, resetb          : clock, asynchronous active-low reset
//   i2c_* / uart_*       : host address, wdata, reg_en, write_en in; rdata out
//   rb_*                 : registered register-bank request, rb_data_read in
//   owner                : FSM state (0 IDLE, 1 I2C, 2 UART)
//   drop_cnt_i2c/_uart   : saturating dropped-access counters
//   clr_drop             : synchronous clear of both drop counters
module rb_access_arbiter
  import rb_access_arbiter_pkg::*;
#(
  parameter int IDLE_TIMEOUT = 1024,
  parameter int CNT_W        = 8,
  parameter bit PRIO_UART    = 1'b1
) (
  input  logic                 clk,
  input  logic                 resetb,
  input  logic [RB_ADDR_W-1:0] i2c_address,
  input  logic [RB_DATA_W-1:0] i2c_wdata,
  input  logic                 i2c_reg_en,
  input  logic                 i2c_write_en,
  output logic [RB_DATA_W-1:0] i2c_rdata,
  input  logic [RB_ADDR_W-1:0] uart_address,
  input  logic [RB_DATA_W-1:0] uart_wdata,
  input  logic                 uart_reg_en,
  input  logic                 uart_write_en,
  output logic [RB_DATA_W-1:0] uart_rdata,
  output logic [RB_ADDR_W-1:0] rb_address,
  output logic [RB_DATA_W-1:0] rb_data_write,
  output logic                 rb_reg_en,
  output logic                 rb_write_en,
  input  logic [RB_DATA_W-1:0] rb_data_read,
  output logic [1:0]           owner,
  output logic [CNT_W-1:0]     drop_cnt_i2c,
  output logic [CNT_W-1:0]     drop_cnt_uart,
  input  logic                 clr_drop
);

  localparam int IDLE_W = $clog2(IDLE_TIMEOUT);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);

  rb_arb_owner_t     state;
  rb_arb_owner_t     state_next;
  logic [IDLE_W-1:0] idle_cnt;
  logic [IDLE_W-1:0] idle_cnt_next;
  logic              owner_en;
  logic              expire;
  logic              sel_i2c;
  logic              sel_uart;

  always_comb begin
    owner_en = 1'b0;
    case (state)
      ARB_I2C:  owner_en = i2c_reg_en;
      ARB_UART: owner_en = uart_reg_en;
      default:  owner_en = 1'b0;
    endcase
  end

  // Last quiet cycle of a session: this cycle is arbitrated as if IDLE, so a
  // waiting host can take over directly without its request being dropped.
  assign expire = (state != ARB_IDLE) && !owner_en && (idle_cnt == IDLE_LAST);

  // State register.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state    <= ARB_IDLE;
      idle_cnt <= '0;
    end else begin
      state    <= state_next;
      idle_cnt <= idle_cnt_next;
    end
  end

  // Next-state and host selection.
  always_comb begin
    sel_i2c    = 1'b0;
    sel_uart   = 1'b0;
    state_next = state;
    if ((state == ARB_IDLE) || expire) begin
      if (i2c_reg_en && uart_reg_en) begin
        sel_uart = PRIO_UART;
        sel_i2c  = !PRIO_UART;
      end else begin
        sel_uart = uart_reg_en;
        sel_i2c  = i2c_reg_en;
      end
      if (sel_uart) begin
        state_next = ARB_UART;
      end else if (sel_i2c) begin
        state_next = ARB_I2C;
      end else begin
        state_next = ARB_IDLE;
      end
    end else if (state == ARB_I2C) begin
      sel_i2c = 1'b1;
    end else begin
      sel_uart = 1'b1;
    end
  end

  // The idle timer restarts on every owner strobe and on every change of
  // ownership, so each session begins with a full timeout window.
  always_comb begin
    if ((state_next == ARB_IDLE) || (state_next != state) || owner_en) begin
      idle_cnt_next = '0;
    end else begin
      idle_cnt_next = idle_cnt + IDLE_W'(1);
    end
  end

  // Register-bank request register. write_en is qualified by reg_en so a
  // write can never appear without an access strobe.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      rb_address    <= '0;
      rb_data_write <= '0;
      rb_reg_en     <= 1'b0;
      rb_write_en   <= 1'b0;
    end else if (sel_i2c) begin
      rb_address    <= i2c_address;
      rb_data_write <= i2c_wdata;
      rb_reg_en     <= i2c_reg_en;
      rb_write_en   <= i2c_reg_en & i2c_write_en;
    end else if (sel_uart) begin
      rb_address    <= uart_address;
      rb_data_write <= uart_wdata;
      rb_reg_en     <= uart_reg_en;
      rb_write_en   <= uart_reg_en & uart_write_en;
    end else begin
      rb_address    <= '0;
      rb_data_write <= '0;
      rb_reg_en     <= 1'b0;
      rb_write_en   <= 1'b0;
    end
  end

  // State-decoded outputs: only the current owner sees read data.
  always_comb begin
    owner      = state;
    i2c_rdata  = (state == ARB_I2C)  ? rb_data_read : '0;
    uart_rdata = (state == ARB_UART) ? rb_data_read : '0;
  end

  rb_arb_drop_cnt #(.CNT_W(CNT_W)) u_drop_i2c (
    .clk      (clk),
    .resetb   (resetb),
    .reg_en   (i2c_reg_en),
    .selected (sel_i2c),
    .clr      (clr_drop),
    .cnt      (drop_cnt_i2c)
  );

  rb_arb_drop_cnt #(.CNT_W(CNT_W)) u_drop_uart (
    .clk      (clk),
    .resetb   (resetb),
    .reg_en   (uart_reg_en),
    .selected (sel_uart),
    .clr      (clr_drop),
    .cnt      (drop_cnt_uart)
  );

endmodule

// File: tb/tb_rb_access_arbiter.sv
// Bench for rb_access_arbiter. Three instances share one set of host inputs:
//   0: UART priority, 8-bit counters
//   1: I2C priority,  8-bit counters
//   2: UART priority, 2-bit counters
// Each instance is followed by a session-level reference model.
module tb_rb_access_arbiter;

  localparam int TIMEOUT = 16;
  localparam int NI      = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic resetb;

  // ---------------- DUT signals ----------------
  logic [7:0] i2c_address, i2c_wdata, uart_address, uart_wdata;
  logic       i2c_reg_en, i2c_write_en, uart_reg_en, uart_write_en, clr_drop;

  logic [7:0] rb_address [NI];
  logic [7:0] rb_data_write [NI];
  logic [7:0] rb_data_read [NI];
  logic [7:0] i2c_rdata [NI];
  logic [7:0] uart_rdata [NI];
  logic       rb_reg_en [NI];
  logic       rb_write_en [NI];
  logic [1:0] owner [NI];
  logic [7:0] dc_i2c_a, dc_uart_a, dc_i2c_b, dc_uart_b;
  logic [1:0] dc_i2c_c, dc_uart_c;
  logic [7:0] drop_i2c [NI];
  logic [7:0] drop_uart [NI];

  always_comb begin
    drop_i2c[0]  = dc_i2c_a;
    drop_uart[0] = dc_uart_a;
    drop_i2c[1]  = dc_i2c_b;
    drop_uart[1] = dc_uart_b;
    drop_i2c[2]  = {6'b0, dc_i2c_c};
    drop_uart[2] = {6'b0, dc_uart_c};
  end

  // Register bank stand-in: read data is a fixed function of the address.
  assign rb_data_read[0] = rb_address[0] ^ 8'h5A;
  assign rb_data_read[1] = rb_address[1] ^ 8'h5A;
  assign rb_data_read[2] = rb_address[2] ^ 8'h5A;

  rb_access_arbiter #(.IDLE_TIMEOUT(TIMEOUT), .CNT_W(8), .PRIO_UART(1'b1)) u_dut_a (
    .clk(clk), .resetb(resetb),
    .i2c_address(i2c_address), .i2c_wdata(i2c_wdata), .i2c_reg_en(i2c_reg_en),
    .i2c_write_en(i2c_write_en), .i2c_rdata(i2c_rdata[0]),
    .uart_address(uart_address), .uart_wdata(uart_wdata), .uart_reg_en(uart_reg_en),
    .uart_write_en(uart_write_en), .uart_rdata(uart_rdata[0]),
    .rb_address(rb_address[0]), .rb_data_write(rb_data_write[0]), .rb_reg_en(rb_reg_en[0]),
    .rb_write_en(rb_write_en[0]), .rb_data_read(rb_data_read[0]), .owner(owner[0]),
    .drop_cnt_i2c(dc_i2c_a), .drop_cnt_uart(dc_uart_a), .clr_drop(clr_drop)
  );

  rb_access_arbiter #(.IDLE_TIMEOUT(TIMEOUT), .CNT_W(8), .PRIO_UART(1'b0)) u_dut_b (
    .clk(clk), .resetb(resetb),
    .i2c_address(i2c_address), .i2c_wdata(i2c_wdata), .i2c_reg_en(i2c_reg_en),
    .i2c_write_en(i2c_write_en), .i2c_rdata(i2c_rdata[1]),
    .uart_address(uart_address), .uart_wdata(uart_wdata), .uart_reg_en(uart_reg_en),
    .uart_write_en(uart_write_en), .uart_rdata(uart_rdata[1]),
    .rb_address(rb_address[1]), .rb_data_write(rb_data_write[1]), .rb_reg_en(rb_reg_en[1]),
    .rb_write_en(rb_write_en[1]), .rb_data_read(rb_data_read[1]), .owner(owner[1]),
    .drop_cnt_i2c(dc_i2c_b), .drop_cnt_uart(dc_uart_b), .clr_drop(clr_drop)
  );

  rb_access_arbiter #(.IDLE_TIMEOUT(TIMEOUT), .CNT_W(2), .PRIO_UART(1'b1)) u_dut_c (
    .clk(clk), .resetb(resetb),
    .i2c_address(i2c_address), .i2c_wdata(i2c_wdata), .i2c_reg_en(i2c_reg_en),
    .i2c_write_en(i2c_write_en), .i2c_rdata(i2c_rdata[2]),
    .uart_address(uart_address), .uart_wdata(uart_wdata), .uart_reg_en(uart_reg_en),
    .uart_write_en(uart_write_en), .uart_rdata(uart_rdata[2]),
    .rb_address(rb_address[2]), .rb_data_write(rb_data_write[2]), .rb_reg_en(rb_reg_en[2]),
    .rb_write_en(rb_write_en[2]), .rb_data_read(rb_data_read[2]), .owner(owner[2]),
    .drop_cnt_i2c(dc_i2c_c), .drop_cnt_uart(dc_uart_c), .clr_drop(clr_drop)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // owner: 0 none, 1 I2C, 2 UART. quiet: owner cycles since its last strobe.
  int         p_prio [NI] = '{1, 0, 1};
  int         p_max  [NI] = '{255, 255, 3};
  int         m_owner [NI];
  int         m_quiet [NI];
  int         m_cnt_i [NI];
  int         m_cnt_u [NI];
  bit         m_prev_i [NI];
  bit         m_prev_u [NI];
  logic [7:0] m_addr [NI];
  logic [7:0] m_wdata [NI];
  bit         m_en [NI];
  bit         m_we [NI];

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_owner[k] = 0; m_quiet[k] = 0; m_cnt_i[k] = 0; m_cnt_u[k] = 0;
      m_prev_i[k] = 0; m_prev_u[k] = 0; m_addr[k] = '0; m_wdata[k] = '0;
      m_en[k] = 0; m_we[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < NI; k++) begin
      int  rules;
      int  win;
      bit  own_en;
      bit  lost_i;
      bit  lost_u;
      own_en = (m_owner[k] == 1) ? i2c_reg_en : (m_owner[k] == 2) ? uart_reg_en : 1'b0;
      // A session that has been quiet for the full window ends this cycle.
      rules = m_owner[k];
      if (rules != 0 && !own_en && m_quiet[k] == TIMEOUT - 1) rules = 0;
      if (rules != 0) win = rules;
      else if (i2c_reg_en && uart_reg_en) win = (p_prio[k] != 0) ? 2 : 1;
      else if (uart_reg_en) win = 2;
      else if (i2c_reg_en) win = 1;
      else win = 0;
      lost_i = i2c_reg_en && !m_prev_i[k] && win != 1;
      lost_u = uart_reg_en && !m_prev_u[k] && win != 2;
      if (win == 1) begin
        m_addr[k] = i2c_address; m_wdata[k] = i2c_wdata;
        m_en[k] = i2c_reg_en; m_we[k] = i2c_reg_en && i2c_write_en;
      end else if (win == 2) begin
        m_addr[k] = uart_address; m_wdata[k] = uart_wdata;
        m_en[k] = uart_reg_en; m_we[k] = uart_reg_en && uart_write_en;
      end else begin
        m_addr[k] = '0; m_wdata[k] = '0; m_en[k] = 0; m_we[k] = 0;
      end
      m_quiet[k] = (win != 0 && win == m_owner[k] && !own_en) ? m_quiet[k] + 1 : 0;
      m_owner[k] = win;
      if (clr_drop) begin
        m_cnt_i[k] = 0; m_cnt_u[k] = 0;
      end else begin
        if (lost_i && m_cnt_i[k] < p_max[k]) m_cnt_i[k]++;
        if (lost_u && m_cnt_u[k] < p_max[k]) m_cnt_u[k]++;
      end
      m_prev_i[k] = i2c_reg_en;
      m_prev_u[k] = uart_reg_en;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NI; k++) begin
      check($sformatf("owner[%0d]", k), owner[k], m_owner[k]);
      check($sformatf("rb_address[%0d]", k), rb_address[k], m_addr[k]);
      check($sformatf("rb_data_write[%0d]", k), rb_data_write[k], m_wdata[k]);
      check($sformatf("rb_reg_en[%0d]", k), rb_reg_en[k], m_en[k]);
      check($sformatf("rb_write_en[%0d]", k), rb_write_en[k], m_we[k]);
      check($sformatf("drop_i2c[%0d]", k), drop_i2c[k], m_cnt_i[k]);
      check($sformatf("drop_uart[%0d]", k), drop_uart[k], m_cnt_u[k]);
      check($sformatf("i2c_rdata[%0d]", k), i2c_rdata[k],
            (m_owner[k] == 1) ? (m_addr[k] ^ 8'h5A) : 8'h00);
      check($sformatf("uart_rdata[%0d]", k), uart_rdata[k],
            (m_owner[k] == 2) ? (m_addr[k] ^ 8'h5A) : 8'h00);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    i2c_address = '0; i2c_wdata = '0; i2c_reg_en = 0; i2c_write_en = 0;
    uart_address = '0; uart_wdata = '0; uart_reg_en = 0; uart_write_en = 0;
    clr_drop = 0;
  endtask

  task automatic drive_i2c(input bit en, input bit we, input logic [7:0] a, input logic [7:0] d);
    i2c_reg_en = en; i2c_write_en = we; i2c_address = a; i2c_wdata = d;
  endtask

  task automatic drive_uart(input bit en, input bit we, input logic [7:0] a, input logic [7:0] d);
    uart_reg_en = en; uart_write_en = we; uart_address = a; uart_wdata = d;
  endtask

  // One clock: model advances on the edge, outputs compared half a cycle later.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int pi;
    int pu;
    logic [1:0] exp_owner;

    // Reset held with both hosts strobing.
    idle_inputs();
    resetb = 1'b0;
    drive_i2c(1, 1, 8'h11, 8'h22);
    drive_uart(1, 1, 8'h33, 8'h44);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("rst_owner[%0d]", k), owner[k], 2'd0);
      check($sformatf("rst_rb_en[%0d]", k), {rb_reg_en[k], rb_write_en[k]}, 2'b00);
      check($sformatf("rst_rb_addr[%0d]", k), rb_address[k], 8'h00);
      check($sformatf("rst_rb_wdata[%0d]", k), rb_data_write[k], 8'h00);
      check($sformatf("rst_drop[%0d]", k), {drop_i2c[k], drop_uart[k]}, 16'h0);
      check($sformatf("rst_rdata[%0d]", k), {i2c_rdata[k], uart_rdata[k]}, 16'h0);
    end
    idle_inputs();
    @(negedge clk);
    resetb = 1'b1;

    // UART write from IDLE.
    drive_uart(1, 1, 8'h03, 8'h80);
    tick();
    check("t2_addr", rb_address[0], 8'h03);
    check("t2_wdata", rb_data_write[0], 8'h80);
    check("t2_we", rb_write_en[0], 1'b1);
    check("t2_owner", owner[0], 2'd2);
    check("t2_uart_rdata", uart_rdata[0], 8'h59);

    // Three I2C writes while UART owns.
    drive_uart(0, 0, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) begin
      drive_i2c(1, 1, 8'h10, 8'hAA);
      tick();
      check("t3_no_write", rb_write_en[0], 1'b0);
      check("t3_i2c_rdata", i2c_rdata[0], 8'h00);
      drive_i2c(0, 0, 8'h00, 8'h00);
      tick();
    end
    check("t3_drop_i2c", drop_i2c[0], 8'd3);

    // Timeout exactly TIMEOUT clocks after the last UART strobe.
    drive_uart(1, 0, 8'h05, 8'h00);
    tick();
    drive_uart(0, 0, 8'h00, 8'h00);
    for (int n = 1; n <= TIMEOUT; n++) exp_q.push_back((n < TIMEOUT) ? 2'd2 : 2'd0);
    while (exp_q.size() > 0) begin
      tick();
      exp_owner = exp_q.pop_front();
      check("t4_owner_trace", owner[0], exp_owner);
    end

    // I2C request on the expiry clock is granted directly, not dropped.
    drive_uart(1, 0, 8'h06, 8'h00);
    tick();
    drive_uart(0, 0, 8'h00, 8'h00);
    ticks(TIMEOUT - 1);
    check("t4b_still_uart", owner[0], 2'd2);
    drive_i2c(1, 1, 8'h20, 8'h33);
    tick();
    check("t4b_owner", owner[0], 2'd1);
    check("t4b_drop", drop_i2c[0], 8'd3);
    check("t4b_addr", rb_address[0], 8'h20);
    check("t4b_we", rb_write_en[0], 1'b1);
    drive_i2c(0, 0, 8'h00, 8'h00);
    ticks(TIMEOUT);
    check("t4b_release", owner[0], 2'd0);

    // Simultaneous first request from IDLE.
    drive_i2c(1, 0, 8'h30, 8'h00);
    drive_uart(1, 0, 8'h31, 8'h00);
    tick();
    check("t5_prio_uart_owner", owner[0], 2'd2);
    check("t5_prio_uart_drop", drop_i2c[0], 8'd4);
    check("t5_prio_i2c_owner", owner[1], 2'd1);
    check("t5_prio_i2c_drop", drop_uart[1], 8'd1);
    drive_i2c(0, 0, 8'h00, 8'h00);
    drive_uart(0, 0, 8'h00, 8'h00);
    ticks(TIMEOUT);

    // Saturation with a 2-bit counter, then clear beating an increment.
    clr_drop = 1;
    tick();
    check("t6_clr", drop_i2c[2], 8'd0);
    clr_drop = 0;
    drive_uart(1, 0, 8'h40, 8'h00);
    tick();
    drive_uart(0, 0, 8'h00, 8'h00);
    for (int i = 0; i < 5; i++) begin
      drive_i2c(1, 1, 8'h41, 8'h42);
      tick();
      drive_i2c(0, 0, 8'h00, 8'h00);
      tick();
    end
    check("t6_sat", drop_i2c[2], 8'd3);
    check("t6_wide", drop_i2c[0], 8'd5);
    drive_i2c(1, 1, 8'h41, 8'h42);
    clr_drop = 1;
    tick();
    check("t6_clr_wins", drop_i2c[2], 8'd0);
    clr_drop = 0;
    drive_i2c(0, 0, 8'h00, 8'h00);
    ticks(TIMEOUT);

    // Reset in the middle of a write.
    drive_uart(1, 1, 8'h44, 8'h55);
    tick();
    check("t7_we_before", rb_write_en[0], 1'b1);
    #2 resetb = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      check($sformatf("t7_we[%0d]", k), rb_write_en[k], 1'b0);
      check($sformatf("t7_en[%0d]", k), rb_reg_en[k], 1'b0);
      check($sformatf("t7_addr[%0d]", k), rb_address[k], 8'h00);
      check($sformatf("t7_owner[%0d]", k), owner[k], 2'd0);
      check($sformatf("t7_rdata[%0d]", k), uart_rdata[k], 8'h00);
    end
    model_reset();
    idle_inputs();
    @(negedge clk);
    resetb = 1'b1;

    // Randomized traffic in segments of varying activity.
    for (int seg = 0; seg < 60; seg++) begin
      pi = $urandom_range(0, 3) * 25;
      pu = $urandom_range(0, 3) * 25;
      for (int c = 0; c < 40; c++) begin
        drive_i2c($urandom_range(0, 99) < pi, $urandom_range(0, 1) == 1,
                  8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        drive_uart($urandom_range(0, 99) < pu, $urandom_range(0, 1) == 1,
                   8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        clr_drop = ($urandom_range(0, 63) == 0);
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
